// File: rtl/serial_add_pkg.sv
// Shared types and constants for the byte-serial adder sequencer.
// State encodings are fixed so the illegal code 2'b11 is well defined.
package serial_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Ceiling log2 with a floor of one bit, so a single-byte build still has a counter.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/Adder.sv
// 8-bit combinational adder with carry in/out; the only arithmetic in the
// sequencer datapath.
module Adder (
    input  logic [7:0] iData_a,
    input  logic [7:0] iData_b,
    input  logic       iC,
    output logic [7:0] oData,
    output logic       oData_C
);

    assign {oData_C, oData} = {1'b0, iData_a} + {1'b0, iData_b} + 9'(iC);

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-byte add sequencer: streams two BYTES-wide operands LSB byte first
// through one 8-bit Adder, chaining carry through a register.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iStart,
    input  logic [8*BYTES-1:0]    iData_a,
    input  logic [8*BYTES-1:0]    iData_b,
    input  logic                  iC,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [8*BYTES-1:0]    oData,
    output logic                  oData_C,
    output logic                  oOverflow
);

    localparam int              W    = BYTE_W * BYTES;
    localparam int              CW   = clog2_min1(BYTES);
    localparam logic [CW-1:0]   LAST = CW'(BYTES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [W-1:0]        a_sr;
    logic [W-1:0]        b_sr;
    logic [W-1:0]        res;
    logic                cr;
    logic [CW-1:0]       cnt;
    logic                data_c;
    logic                ovf;
    logic [BYTE_W-1:0]   sum_byte;
    logic                sum_c;

    Adder u_adder (
        .iData_a (a_sr[BYTE_W-1:0]),
        .iData_b (b_sr[BYTE_W-1:0]),
        .iC      (cr),
        .oData   (sum_byte),
        .oData_C (sum_c)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (iStart) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, so an aborted add leaves no
    // stale partial sum visible on oData.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            cr     <= 1'b0;
            cnt    <= '0;
            data_c <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        a_sr   <= iData_a;
                        b_sr   <= iData_b;
                        cr     <= iC;
                        cnt    <= '0;
                        data_c <= 1'b0;
                        ovf    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Sum bytes enter at the top and walk down to their final lane.
                    res  <= (res >> BYTE_W) | (W'(sum_byte) << (W - BYTE_W));
                    cr   <= sum_c;
                    a_sr <= a_sr >> BYTE_W;
                    b_sr <= b_sr >> BYTE_W;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        data_c <= sum_c;
                        ovf    <= (a_sr[BYTE_W-1] == b_sr[BYTE_W-1]) &&
                                  (sum_byte[BYTE_W-1] != a_sr[BYTE_W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy     = (state == ST_RUN) || (state == ST_DONE);
    assign oDone     = (state == ST_DONE);
    assign oData     = res;
    assign oData_C   = data_c;
    assign oOverflow = ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a 4-byte instance for the main
// scenarios and a 1-byte instance for the single-cycle RUN case.
module tb_serial_add_ctrl;

    localparam int W4 = 32;
    localparam int W1 = 8;

    typedef struct packed {
        logic [63:0] data;
        logic        c;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start, c_in, busy, done, data_c, ovf;
    logic [W4-1:0] a, b, data;
    logic          start1, c1, busy1, done1, data_c1, ovf1;
    logic [W1-1:0] a1, b1, data1;

    exp_t sb4[$];
    exp_t sb1[$];
    int   checks = 0;
    int   errors = 0;

    serial_add_ctrl #(.BYTES(4)) dut4 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start),
        .iData_a(a), .iData_b(b), .iC(c_in),
        .oBusy(busy), .oDone(done), .oData(data),
        .oData_C(data_c), .oOverflow(ovf)
    );

    serial_add_ctrl #(.BYTES(1)) dut1 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start1),
        .iData_a(a1), .iData_b(b1), .iC(c1),
        .oBusy(busy1), .oDone(done1), .oData(data1),
        .oData_C(data_c1), .oOverflow(ovf1)
    );

    // Full-width reference: plain addition, overflow from the operand/sum sign bits.
    function automatic exp_t model(input logic [63:0] ia, input logic [63:0] ib,
                                   input logic ic, input int w);
        logic [64:0] s;
        logic [63:0] mask;
        exp_t        e;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        s      = {1'b0, ia & mask} + {1'b0, ib & mask} + 65'(ic);
        e.data = s[63:0] & mask;
        e.c    = s[w];
        e.ovf  = (ia[w-1] == ib[w-1]) && (s[w-1] != ia[w-1]);
        return e;
    endfunction

    task automatic run_op(input logic [W4-1:0] ia, input logic [W4-1:0] ib,
                          input logic ic, input string name);
        exp_t e;
        int   cyc;
        logic seen;
        @(negedge clk);
        a = ia; b = ib; c_in = ic; start = 1'b1;
        sb4.push_back(model(64'(ia), 64'(ib), ic, W4));
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen = done;
        end
        checks++;
        if (!seen || cyc != 5) begin
            errors++;
            $display("FAIL %s latency: got cycle %0d (seen %0b) expected 5", name, cyc, seen);
        end
        e = sb4.pop_front();
        checks++;
        if (data !== e.data[W4-1:0]) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, data, e.data[W4-1:0]);
        end
        checks++;
        if (data_c !== e.c) begin
            errors++;
            $display("FAIL %s carry: got %b expected %b", name, data_c, e.c);
        end
        checks++;
        if (ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s overflow: got %b expected %b", name, ovf, e.ovf);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        int extra;
        start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, data, data_c, ovf} !== '0) begin
            errors++;
            $display("FAIL reset4: got busy=%b done=%b data=%h c=%b ovf=%b expected all 0",
                     busy, done, data, data_c, ovf);
        end
        checks++;
        if ({busy1, done1, data1, data_c1, ovf1} !== '0) begin
            errors++;
            $display("FAIL reset1: got busy=%b done=%b data=%h c=%b ovf=%b expected all 0",
                     busy1, done1, data1, data_c1, ovf1);
        end
        rst_n = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || done1 || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_basic();
        run_op(32'h0000_0001, 32'h0000_0001, 1'b1, "basic");
    endtask

    task automatic test_ripple();
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "ripple_ones");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, "ripple_msb");
    endtask

    task automatic test_overflow();
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "signed_ovf");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            a = 32'h41; b = 32'hC1; c_in = 1'b0;
            sb4.push_back(model(64'h41, 64'hC1, 1'b0, W4));
            @(posedge clk);
            for (int cyc = 1; cyc <= 6; cyc++) begin
                @(negedge clk);
                checks++;
                if (done !== (cyc == 5) || busy !== (cyc <= 5)) begin
                    errors++;
                    $display("FAIL b2b op%0d cycle%0d: got done=%b busy=%b expected %b %b",
                             op, cyc, done, busy, (cyc == 5), (cyc <= 5));
                end
                if (cyc == 5) begin
                    e = sb4.pop_front();
                    checks++;
                    if ({data, data_c, ovf} !== {e.data[W4-1:0], e.c, e.ovf}) begin
                        errors++;
                        $display("FAIL b2b op%0d result: got %h/%b/%b expected %h/%b/%b",
                                 op, data, data_c, ovf, e.data[W4-1:0], e.c, e.ovf);
                    end
                end
                if (cyc < 6) begin
                    a = $urandom; b = $urandom; c_in = 1'($urandom_range(1));
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_abort();
        int extra;
        @(negedge clk);
        a = 32'h78; b = 32'h78; c_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, data, data_c, ovf} !== '0) begin
            errors++;
            $display("FAIL abort_clear: got busy=%b done=%b data=%h c=%b ovf=%b expected all 0",
                     busy, done, data, data_c, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", extra);
        end
        run_op(32'h78, 32'h78, 1'b1, "post_abort");
    endtask

    task automatic test_bytes1();
        exp_t e;
        int   cyc;
        logic seen;
        @(negedge clk);
        a1 = 8'hFF; b1 = 8'hFF; c1 = 1'b1; start1 = 1'b1;
        sb1.push_back(model(64'hFF, 64'hFF, 1'b1, W1));
        @(posedge clk);
        #1;
        start1 = 1'b0; a1 = 8'h00; b1 = 8'h00; c1 = 1'b0;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen = done1;
        end
        checks++;
        if (!seen || cyc != 2) begin
            errors++;
            $display("FAIL bytes1 latency: got cycle %0d (seen %0b) expected 2", cyc, seen);
        end
        e = sb1.pop_front();
        checks++;
        if ({data1, data_c1, ovf1} !== {e.data[W1-1:0], e.c, e.ovf}) begin
            errors++;
            $display("FAIL bytes1 result: got %h/%b/%b expected %h/%b/%b",
                     data1, data_c1, ovf1, e.data[W1-1:0], e.c, e.ovf);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL bytes1 done_pulse: got %b expected 0", done1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_bytes1();
        checks++;
        if (sb4.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", sb4.size(), sb1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Multi-byte serial addition sequencer that sits directly upstream of the 8-bit `Adder` datapath and drives its operand and carry inputs. It accepts two BYTES-wide operands and a carry-in, then streams them LSB byte first through one `Adder` instance, one byte per clock, chaining carry through a register. It assembles the full-width sum, final carry and signed overflow, and reports completion with a one-cycle done pulse.

## Interface
Parameters:
- BYTES, 4, operand width in bytes; legal range 1..8.

Ports:
- iClk  input  1  system clock; all state changes on the rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iStart  input  1  start request; sampled only in IDLE.
- iData_a  input  8*BYTES  operand A, unsigned or two's complement.
- iData_b  input  8*BYTES  operand B.
- iC  input  1  carry-in for byte 0.
- oBusy  output  1  high in RUN and DONE.
- oDone  output  1  one-cycle completion pulse.
- oData  output  8*BYTES  sum.
- oData_C  output  1  carry out of the MSB byte.
- oOverflow  output  1  signed overflow of the full-width add.

## Operation
- States and encodings: IDLE (2'b00), RUN (2'b01), DONE (2'b10). Encoding 2'b11 is illegal and returns to IDLE.
- **IDLE**
  - If iStart=1: capture iData_a and iData_b into operand shift registers A and B, load carry register cr with iC, clear byte counter cnt, clear oData_C and oOverflow, then go to RUN.
  - If iStart=0: hold all registers.
- **RUN** (one byte per cycle)
  - `Adder` sees iData_a=A[7:0], iData_b=B[7:0], iC=cr.
  - On the clock edge:
    - Shift the result register right by 8 and insert the `Adder` oData byte at the top byte.
    - Load cr with the `Adder` oData_C.
    - Shift A and B right by 8 and increment cnt.
    - Save the MSB of the current A byte and of the current B byte (sign bits).
  - When cnt==BYTES-1, go to DONE on that edge. On the same edge:
    - oData_C <= `Adder` oData_C.
    - oOverflow <= (a_msb==b_msb) && (sum_msb!=a_msb), where a_msb, b_msb and sum_msb are bit 7 of the final A byte, B byte and `Adder` sum byte.
- **DONE:** oDone=1 for exactly one cycle, then go to IDLE unconditionally.
- **Output validity**
  - oData, oData_C and oOverflow are valid from the DONE cycle until the next iStart is accepted.
  - oData changes during RUN (partial shift contents) and must not be used then.
- **Arithmetic:** {oData_C, oData} = iData_a + iData_b + iC, modulo 2^(8*BYTES+1).
- **Boundary conditions**
  - iStart in RUN or DONE is ignored; it is not queued.
  - Operand inputs are don't-care outside the IDLE start cycle.
  - BYTES=1: RUN lasts a single cycle.
  - A carry ripple across every byte (e.g. all-ones + 1) must complete correctly through cr.
- **Reset:** iRst_n low at any time, including mid-RUN, immediately forces IDLE and clears all registers and outputs. No oDone is issued for an aborted operation.

## Timing
- Reset values: oBusy=0, oDone=0, oData=0, oData_C=0, oOverflow=0, state=IDLE.
- Accept: iStart sampled high at edge E0. oBusy rises after E0.
- RUN occupies edges E0+1 .. E0+BYTES.
- oDone is high in the cycle following edge E0+BYTES, i.e. latency BYTES+1 cycles from accept.
- Earliest next accept is edge E0+BYTES+2, giving a throughput of one add per BYTES+2 cycles.
- oBusy and oDone are registered outputs; no combinational path from iStart to any output.
- The `Adder` instance is purely combinational inside one cycle; critical path is the 8-bit ripple plus the result-register mux.

## Structure
- Shared package `serial_add_pkg`:
  - state localparams ST_IDLE, ST_RUN, ST_DONE;
  - BYTE_W=8;
  - counter width function clog2(BYTES) with a minimum of 1.
- One sub-module: the existing `Adder` (8-bit, ports iData_a, iData_b, iC, oData, oData_C), instantiated once. No other arithmetic is in this block.
- Counter width: clog2(BYTES), minimum 1 bit.

## Test plan
All scenarios use BYTES=4 unless stated.
- **Reset:** hold iRst_n=0 for 3 cycles -> all outputs 0, oBusy=0. Release, wait 5 cycles -> no oDone.
- **Basic add:** a=0x00000001, b=0x00000001, iC=1 -> oData=0x00000003, oData_C=0, oOverflow=0. oDone exactly 5 cycles after the accept edge, high for 1 cycle.
- **Full ripple:**
  - a=0xFFFFFFFF, b=0x00000001, iC=0 -> oData=0x00000000, oData_C=1, oOverflow=0.
  - a=0x80000000, b=0x80000000, iC=0 -> oData=0x00000000, oData_C=1, oOverflow=1.
- **Signed overflow:** a=0x7FFFFFFF, b=0x00000001, iC=0 -> oData=0x80000000, oData_C=0, oOverflow=1.
- **Start while busy:** hold iStart=1 continuously with a=0x41, b=0xC1, iC=0 -> oData=0x00000102. One oDone every 6 cycles. Operands changed during RUN do not affect the result.
- **Abort and BYTES=1:**
  - Assert iRst_n=0 on the 2nd RUN cycle -> outputs clear immediately, no oDone. The next start (a=0x78, b=0x78, iC=1) yields oData=0x000000F1.
  - Separate BYTES=1 build: a=0xFF, b=0xFF, iC=1 -> oData=0xFF, oData_C=1, oDone 2 cycles after accept.
